line_engine: RTL and testbench
==============================

LINE_ENGINE -- requirements
Module: line_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 800, meaning pixels with x >= SCREEN_W are clipped.
REQ-002 SHALL have parameter SCREEN_H, default 600, meaning pixels with y >= SCREEN_H are clipped.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
REQ-004 Command ports (CPU side):
- line_color  in  32  pixel colour; bits [23:0] used.
- line_point  in  10  coordinate value.
- line_color_valid  in  1  one-cycle strobe; latch colour.
- line_x0_valid  in  1  one-cycle strobe; latch x0.
- line_y0_valid  in  1  one-cycle strobe; latch y0.
- line_x1_valid  in  1  one-cycle strobe; latch x1.
- line_y1_valid  in  1  one-cycle strobe; latch y1.
- line_trigger  in  1  one-cycle strobe; start a line.
- line_ready  out  1  high when idle and able to accept line_trigger.
REQ-005 Pixel port (frame-buffer side):
- px_valid  out  1  pixel request valid.
- px_ready  in  1  sink accepts pixel.
- px_x  out  10  pixel column.
- px_y  out  10  pixel row.
- px_color  out  24  pixel colour.

Function
REQ-006 Each *_valid strobe SHALL latch its operand into a shadow register on that edge, in any state; shadow registers affect only the next triggered line.
REQ-007 On line_trigger while line_ready=1, the engine SHALL snapshot all shadow registers, including any written in the same cycle, and leave IDLE.
REQ-008 line_trigger while line_ready=0 SHALL be ignored.
REQ-009 FSM states SHALL be IDLE, SETUP, DRAW and DONE:
- IDLE -> SETUP on an accepted trigger.
- SETUP -> DRAW after exactly 1 cycle.
- DRAW -> DONE after the last pixel is accepted or dropped.
- DONE -> IDLE after 1 cycle.
- line_ready=1 only in IDLE.
REQ-010 SETUP computes, using 12-bit signed internal arithmetic:
- steep = |y1-y0| > |x1-x0|; if steep, swap x and y of both endpoints.
- If x0 > x1, swap the endpoints.
- dx = x1-x0; dy = |y1-y0|; err = floor(dx/2); ystep = +1 if y0<y1, else -1.
REQ-011 Each DRAW step SHALL:
- Present (y,x) if steep, else (x,y).
- Then apply err -= dy; if err < 0, y += ystep and err += dx.
- Then x += 1.
- Exactly dx+1 steps occur, both endpoints inclusive.
REQ-012 px_valid SHALL be high in DRAW for each in-screen pixel; px_x, px_y and px_color SHALL stay stable while px_valid=1 and px_ready=0.
REQ-013 A step SHALL advance only when px_valid and px_ready are both high, or when the pixel is clipped.
REQ-014 A clipped pixel SHALL never assert px_valid and SHALL consume one cycle.
REQ-015 Throughput SHALL be 1 pixel/cycle with px_ready held high; the first px_valid SHALL appear 2 cycles after the trigger edge.
REQ-016 Degenerate line (x0=x1, y0=y1) SHALL emit exactly one pixel.
REQ-017 px_valid SHALL be 0 in IDLE, SETUP and DONE.

Reset
REQ-018 While rst_n=0, asynchronously:
- state=IDLE, line_ready=1, px_valid=0, px_x=0, px_y=0, px_color=0.
- All shadow and working registers = 0.
REQ-019 Reset asserted mid-line SHALL abort the line; no further pixels are issued after rst_n rises until a new trigger.

Verification
REQ-020 Horizontal line: points (0,0)->(3,0), colour 0xFF0000, px_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0), each with px_color 0xFF0000, on 4 consecutive cycles; line_ready returns high 2 cycles after the last pixel.
REQ-021 Steep reversed line: points (2,5)->(0,0) -> pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), in that order.
REQ-022 Backpressure: line (0,0)->(2,2) with px_ready low for 3 cycles on the first pixel -> (0,0) is held stable for 4 cycles, then (1,1) and (2,2) follow; exactly 3 pixels are issued.
REQ-023 Clipping: line (798,0)->(801,0) with SCREEN_W=800 -> only (798,0) and (799,0) are issued; the FSM reaches DONE.
REQ-024 Trigger while busy, plus degenerate line: a trigger during DRAW is ignored; a later trigger for (7,7)->(7,7) yields exactly one pixel (7,7).
REQ-025 Reset mid-DRAW: rst_n pulsed low after 2 pixels of (0,0)->(9,0) -> px_valid drops immediately, line_ready=1, and no further pixels are issued.

Source files
------------

// File: rtl/line_engine.sv
// Bresenham line rasteriser: CPU-side shadow registers, per-line snapshot,
// and a pixel stream with valid/ready handshake and screen clipping.
module line_engine #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] line_color,
    input  logic [9:0]  line_point,
    input  logic        line_color_valid,
    input  logic        line_x0_valid,
    input  logic        line_y0_valid,
    input  logic        line_x1_valid,
    input  logic        line_y1_valid,
    input  logic        line_trigger,
    output logic        line_ready,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [23:0] px_color
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam logic signed [11:0] COL_LIM = 12'(SCREEN_W);
    localparam logic signed [11:0] ROW_LIM = 12'(SCREEN_H);

    state_t state, state_next;

    logic [23:0] color_sh, color_w;
    logic [9:0]  x0_sh, y0_sh, x1_sh, y1_sh;
    logic [9:0]  x0_w, y0_w, x1_w, y1_w;

    logic signed [11:0] cur_x, cur_y, x_end, dx, dy, err, ystep;
    logic               steep;

    logic signed [11:0] sx0, sy0, sx1, sy1, adx, ady;
    logic signed [11:0] ax0, ay0, ax1, ay1, bx0, by0, bx1, by1;
    logic signed [11:0] set_dx, set_dy, set_ystep;
    logic               set_steep;

    logic signed [11:0] err_dec, err_next, y_next, pix_col, pix_row;
    logic               in_screen, step_go, last_step, accept;

    logic unused_color_bits;
    assign unused_color_bits = ^line_color[31:24];

    assign accept = line_trigger && (state == IDLE);

    // Shadow registers take their operand on any strobe, regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_sh <= '0;
            x0_sh    <= '0;
            y0_sh    <= '0;
            x1_sh    <= '0;
            y1_sh    <= '0;
        end else begin
            if (line_color_valid) color_sh <= line_color[23:0];
            if (line_x0_valid)    x0_sh    <= line_point;
            if (line_y0_valid)    y0_sh    <= line_point;
            if (line_x1_valid)    x1_sh    <= line_point;
            if (line_y1_valid)    y1_sh    <= line_point;
        end
    end

    // Endpoint normalisation so the loop always walks +1 along the major axis.
    always_comb begin
        sx0 = $signed({2'b00, x0_w});
        sy0 = $signed({2'b00, y0_w});
        sx1 = $signed({2'b00, x1_w});
        sy1 = $signed({2'b00, y1_w});
        adx = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
        ady = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
        set_steep = ady > adx;
        ax0 = set_steep ? sy0 : sx0;
        ay0 = set_steep ? sx0 : sy0;
        ax1 = set_steep ? sy1 : sx1;
        ay1 = set_steep ? sx1 : sy1;
        bx0 = (ax0 > ax1) ? ax1 : ax0;
        by0 = (ax0 > ax1) ? ay1 : ay0;
        bx1 = (ax0 > ax1) ? ax0 : ax1;
        by1 = (ax0 > ax1) ? ay0 : ay1;
        set_dx    = bx1 - bx0;
        set_dy    = (by1 >= by0) ? by1 - by0 : by0 - by1;
        set_ystep = (by0 < by1) ? 12'sd1 : -12'sd1;
    end

    always_comb begin
        err_dec   = err - dy;
        err_next  = (err_dec < 0) ? err_dec + dx : err_dec;
        y_next    = (err_dec < 0) ? cur_y + ystep : cur_y;
        pix_col   = steep ? cur_y : cur_x;
        pix_row   = steep ? cur_x : cur_y;
        in_screen = (pix_col < COL_LIM) && (pix_row < ROW_LIM);
        step_go   = (state == DRAW) && (!in_screen || px_ready);
        last_step = (cur_x == x_end);
    end

    // Working registers: snapshot on accept, setup once, then step per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_w <= '0;
            x0_w    <= '0;
            y0_w    <= '0;
            x1_w    <= '0;
            y1_w    <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            x_end   <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            ystep   <= '0;
            steep   <= 1'b0;
        end else begin
            if (accept) begin
                color_w <= line_color_valid ? line_color[23:0] : color_sh;
                x0_w    <= line_x0_valid ? line_point : x0_sh;
                y0_w    <= line_y0_valid ? line_point : y0_sh;
                x1_w    <= line_x1_valid ? line_point : x1_sh;
                y1_w    <= line_y1_valid ? line_point : y1_sh;
            end
            if (state == SETUP) begin
                cur_x <= bx0;
                cur_y <= by0;
                x_end <= bx1;
                dx    <= set_dx;
                dy    <= set_dy;
                err   <= set_dx >>> 1;
                ystep <= set_ystep;
                steep <= set_steep;
            end else if (step_go) begin
                cur_x <= cur_x + 12'sd1;
                cur_y <= y_next;
                err   <= err_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (step_go && last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        line_ready = (state == IDLE);
        px_valid   = (state == DRAW) && in_screen;
    end

    assign px_x     = pix_col[9:0];
    assign px_y     = pix_row[9:0];
    assign px_color = color_w;

endmodule

// File: tb/tb_line_engine.sv
// Self-checking bench for line_engine: directed lines with literal pixel lists
// plus a line-walk model, scored by a negedge compare process.
module tb_line_engine;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] line_color;
    logic [9:0]  line_point;
    logic        line_color_valid, line_x0_valid, line_y0_valid;
    logic        line_x1_valid, line_y1_valid, line_trigger;
    logic        line_ready, px_valid, px_ready;
    logic [9:0]  px_x, px_y;
    logic [23:0] px_color;

    line_engine #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .line_color(line_color), .line_point(line_point),
        .line_color_valid(line_color_valid),
        .line_x0_valid(line_x0_valid), .line_y0_valid(line_y0_valid),
        .line_x1_valid(line_x1_valid), .line_y1_valid(line_y1_valid),
        .line_trigger(line_trigger), .line_ready(line_ready),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_color(px_color)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    pix_t exp_q[$];

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int accepted = 0, valid_cycles = 0;
    int first_px_cyc = -1, last_acc_cyc = -1, trig_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Every valid pixel is compared with the head of the expected list;
    // the head is only consumed when the handshake completes.
    always @(negedge clk) begin
        if (rst_n && px_valid) begin
            valid_cycles++;
            if (first_px_cyc < 0) first_px_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL extra_pixel: got (%0d,%0d) expected none", px_x, px_y);
            end else if (px_x != exp_q[0].x[9:0] || px_y != exp_q[0].y[9:0] ||
                         px_color != exp_q[0].c[23:0]) begin
                n_fail++;
                $display("[TB] FAIL pixel: got (%0d,%0d,%06h) expected (%0d,%0d,%06h)",
                         px_x, px_y, px_color, exp_q[0].x, exp_q[0].y, exp_q[0].c);
            end
            if (px_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                accepted++;
                last_acc_cyc = cyc;
            end
        end
    end

    // Walks the line as the algorithm describes and lists the visible pixels.
    function automatic int model_line(input int x0, input int y0, input int x1, input int y1,
                                      input int color);
        int ax0, ay0, ax1, ay1, t, ddx, ddy, e, ys, y, n;
        bit st;
        n = 0;
        st = ((y1 > y0 ? y1 - y0 : y0 - y1) > (x1 > x0 ? x1 - x0 : x0 - x1));
        ax0 = st ? y0 : x0; ay0 = st ? x0 : y0;
        ax1 = st ? y1 : x1; ay1 = st ? x1 : y1;
        if (ax0 > ax1) begin
            t = ax0; ax0 = ax1; ax1 = t;
            t = ay0; ay0 = ay1; ay1 = t;
        end
        ddx = ax1 - ax0;
        ddy = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        e = ddx / 2;
        ys = (ay0 < ay1) ? 1 : -1;
        y = ay0;
        for (int x = ax0; x <= ax1; x++) begin
            pix_t p;
            p.x = st ? y : x;
            p.y = st ? x : y;
            p.c = color;
            if (p.x < SCREEN_W && p.y < SCREEN_H) begin
                exp_q.push_back(p);
                n++;
            end
            e -= ddy;
            if (e < 0) begin
                y += ys;
                e += ddx;
            end
        end
        return n;
    endfunction

    task automatic push_pix(input int x, input int y, input int c);
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        exp_q.push_back(p);
    endtask

    // Loads colour and endpoints one strobe per cycle; y1 shares the trigger cycle.
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input int color);
        accepted = 0; valid_cycles = 0; first_px_cyc = -1; last_acc_cyc = -1;
        line_color = 32'hAB000000 | 32'(color); line_color_valid = 1'b1;
        @(posedge clk); #1 line_color_valid = 1'b0;
        line_point = 10'(x0); line_x0_valid = 1'b1;
        @(posedge clk); #1 line_x0_valid = 1'b0;
        line_point = 10'(y0); line_y0_valid = 1'b1;
        @(posedge clk); #1 line_y0_valid = 1'b0;
        line_point = 10'(x1); line_x1_valid = 1'b1;
        @(posedge clk); #1 line_x1_valid = 1'b0;
        line_point = 10'(y1); line_y1_valid = 1'b1; line_trigger = 1'b1;
        trig_cyc = cyc;
        @(posedge clk); #1 line_y1_valid = 1'b0; line_trigger = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (!line_ready && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("line_ready_returns", int'(line_ready), 1);
    endtask

    int cyc_n, n_model;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; line_color = '0; line_point = '0;
        line_color_valid = 0; line_x0_valid = 0; line_y0_valid = 0;
        line_x1_valid = 0; line_y1_valid = 0; line_trigger = 0; px_ready = 1'b1;
        #17;
        checkOutput("reset_line_ready", int'(line_ready), 1);
        checkOutput("reset_px_valid", int'(px_valid), 0);
        checkOutput("reset_px_x", int'(px_x), 0);
        checkOutput("reset_px_y", int'(px_y), 0);
        checkOutput("reset_px_color", int'(px_color), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] horizontal line");
        for (int i = 0; i < 4; i++) push_pix(i, 0, 'hFF0000);
        applyStimulus(0, 0, 3, 0, 'hFF0000);
        checkOutput("setup_no_px_valid", int'(px_valid), 0);
        waitIdle(cyc_n);
        checkOutput("horiz_idle_cycles", cyc_n, 6);
        checkOutput("horiz_first_px_latency", first_px_cyc - trig_cyc, 2);
        checkOutput("horiz_back_to_back", last_acc_cyc - first_px_cyc, 3);
        checkOutput("horiz_ready_after_last", cyc - last_acc_cyc, 2);
        checkOutput("horiz_accepted", accepted, 4);
        checkOutput("horiz_drained", exp_q.size(), 0);

        $display("[TB] steep reversed line");
        push_pix(0, 0, 'h00FF00); push_pix(0, 1, 'h00FF00); push_pix(1, 2, 'h00FF00);
        push_pix(1, 3, 'h00FF00); push_pix(2, 4, 'h00FF00); push_pix(2, 5, 'h00FF00);
        applyStimulus(2, 5, 0, 0, 'h00FF00);
        waitIdle(cyc_n);
        checkOutput("steep_accepted", accepted, 6);
        checkOutput("steep_drained", exp_q.size(), 0);

        $display("[TB] backpressure");
        push_pix(0, 0, 'h123456); push_pix(1, 1, 'h123456); push_pix(2, 2, 'h123456);
        px_ready = 1'b0;
        applyStimulus(0, 0, 2, 2, 'h123456);
        @(posedge clk); #1;
        checkOutput("bp_first_valid", int'(px_valid), 1);
        repeat (3) begin @(posedge clk); #1; end
        px_ready = 1'b1;
        waitIdle(cyc_n);
        checkOutput("bp_valid_cycles", valid_cycles, 6);
        checkOutput("bp_accepted", accepted, 3);
        checkOutput("bp_drained", exp_q.size(), 0);

        $display("[TB] right-edge clipping");
        push_pix(798, 0, 'h0000FF); push_pix(799, 0, 'h0000FF);
        applyStimulus(798, 0, 801, 0, 'h0000FF);
        waitIdle(cyc_n);
        checkOutput("clip_idle_cycles", cyc_n, 6);
        checkOutput("clip_accepted", accepted, 2);
        checkOutput("clip_drained", exp_q.size(), 0);

        $display("[TB] trigger while busy, then degenerate line");
        for (int i = 0; i < 6; i++) push_pix(i, 0, 'hABCDEF);
        applyStimulus(0, 0, 5, 0, 'hABCDEF);
        @(posedge clk); #1;
        line_point = 10'd7; line_x0_valid = 1'b1; line_trigger = 1'b1;
        @(posedge clk); #1 line_x0_valid = 1'b0; line_trigger = 1'b0;
        waitIdle(cyc_n);
        checkOutput("busy_accepted", accepted, 6);
        checkOutput("busy_drained", exp_q.size(), 0);
        push_pix(7, 7, 'h00AA55);
        applyStimulus(7, 7, 7, 7, 'h00AA55);
        waitIdle(cyc_n);
        checkOutput("degen_idle_cycles", cyc_n, 3);
        checkOutput("degen_accepted", accepted, 1);
        checkOutput("degen_drained", exp_q.size(), 0);

        $display("[TB] model-checked lines");
        n_model = model_line(3, 1, 10, 6, 'h111111);
        applyStimulus(3, 1, 10, 6, 'h111111);
        waitIdle(cyc_n);
        checkOutput("model_a_accepted", accepted, n_model);
        checkOutput("model_a_drained", exp_q.size(), 0);
        n_model = model_line(9, 2, 1, 8, 'h222222);
        applyStimulus(9, 2, 1, 8, 'h222222);
        waitIdle(cyc_n);
        checkOutput("model_b_accepted", accepted, n_model);
        checkOutput("model_b_drained", exp_q.size(), 0);
        n_model = model_line(5, 598, 8, 602, 'h333333);
        applyStimulus(5, 598, 8, 602, 'h333333);
        waitIdle(cyc_n);
        checkOutput("model_c_accepted", accepted, n_model);
        checkOutput("model_c_drained", exp_q.size(), 0);

        $display("[TB] reset mid-line");
        n_model = model_line(0, 0, 9, 0, 'h777777);
        applyStimulus(0, 0, 9, 0, 'h777777);
        for (int i = 0; i < 20 && accepted < 2; i++) begin @(posedge clk); #1; end
        checkOutput("rst_two_pixels_before", accepted, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_px_valid_drop", int'(px_valid), 0);
        checkOutput("rst_line_ready", int'(line_ready), 1);
        checkOutput("rst_px_x", int'(px_x), 0);
        checkOutput("rst_px_color", int'(px_color), 0);
        exp_q.delete();
        accepted = 0; valid_cycles = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        checkOutput("rst_no_more_pixels", valid_cycles, 0);
        checkOutput("rst_still_idle", int'(line_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
